// File: rtl/bu2_ifft.sv
// Radix-2 DIT inverse NTT butterfly: (a + b*w) mod q, (a - b*w) mod q.
// Define BU_IFFT_HALF_EN to append a stage that scales both results by 2^-1 mod q.
`ifndef D_width
`define D_width 16
`endif

module bu2_ifft #(
    parameter int              DW   = `D_width,
    parameter int              MU_W = DW + 2,
    parameter logic [MU_W-1:0] MU   = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          flush,
    input  logic [DW-1:0] in1,
    input  logic [DW-1:0] in2,
    input  logic [DW-1:0] twiddle,
    input  logic [DW-1:0] modulus,
    output logic          out_valid,
    output logic [DW-1:0] ifft_a,
    output logic [DW-1:0] ifft_b,
    output logic [DW-1:0] twiddle_out,
    output logic [DW-1:0] modulus_out,
    output logic          busy
);
    localparam int PW = 2 * DW;
    localparam int AW = DW + 1;
    localparam int XW = AW + MU_W;
    localparam int RW = DW + 2;

    logic          v0_q, v0_d;
    logic [DW-1:0] a0_q, a0_d, b0_q, b0_d, w0_q, w0_d, m0_q, m0_d;

    logic          v1_q, v1_d;
    logic [PW-1:0] p1_q, p1_d;
    logic [DW-1:0] a1_q, a1_d, w1_q, w1_d, m1_q, m1_d;

    logic          v2_q, v2_d;
    logic [DW-1:0] t2_q, t2_d, a2_q, a2_d, w2_q, w2_d, m2_q, m2_d;

    logic          v3_q, v3_d;
    logic [DW-1:0] ra3_q, ra3_d, rb3_q, rb3_d, w3_q, w3_d, m3_q, m3_d;

    logic [AW-1:0]   bar_a;
    logic [MU_W-1:0] bar_qe;
    logic [RW-1:0]   bar_r;
    logic [RW-1:0]   bar_r1;
    logic [AW-1:0]   sum3;

    always_comb begin
        v0_d = in_valid & ~flush;
        a0_d = in1;
        b0_d = in2;
        w0_d = twiddle;
        m0_d = modulus;

        v1_d = v0_q & ~flush;
        p1_d = PW'(b0_q) * PW'(w0_q);
        a1_d = a0_q;
        w1_d = w0_q;
        m1_d = m0_q;

        // Barrett estimate is at most two q short, so only low RW bits matter.
        bar_a  = p1_q[PW-1:DW-1];
        bar_qe = MU_W'((XW'(bar_a) * XW'(MU)) >> (DW + 1));
        bar_r  = p1_q[RW-1:0] - RW'(RW'(bar_qe) * RW'(m1_q));
        bar_r1 = (bar_r >= RW'(m1_q)) ? bar_r - RW'(m1_q) : bar_r;
        v2_d   = v1_q & ~flush;
        t2_d   = DW'((bar_r1 >= RW'(m1_q)) ? bar_r1 - RW'(m1_q) : bar_r1);
        a2_d   = a1_q;
        w2_d   = w1_q;
        m2_d   = m1_q;

        sum3  = AW'(a2_q) + AW'(t2_q);
        v3_d  = v2_q & ~flush;
        ra3_d = DW'((sum3 >= AW'(m2_q)) ? sum3 - AW'(m2_q) : sum3);
        rb3_d = (a2_q >= t2_q) ? a2_q - t2_q : a2_q - t2_q + m2_q;
        w3_d  = w2_q;
        m3_d  = m2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q  <= 1'b0;
            a0_q  <= '0;
            b0_q  <= '0;
            w0_q  <= '0;
            m0_q  <= '0;
            v1_q  <= 1'b0;
            p1_q  <= '0;
            a1_q  <= '0;
            w1_q  <= '0;
            m1_q  <= '0;
            v2_q  <= 1'b0;
            t2_q  <= '0;
            a2_q  <= '0;
            w2_q  <= '0;
            m2_q  <= '0;
            v3_q  <= 1'b0;
            ra3_q <= '0;
            rb3_q <= '0;
            w3_q  <= '0;
            m3_q  <= '0;
        end else begin
            v0_q  <= v0_d;
            a0_q  <= a0_d;
            b0_q  <= b0_d;
            w0_q  <= w0_d;
            m0_q  <= m0_d;
            v1_q  <= v1_d;
            p1_q  <= p1_d;
            a1_q  <= a1_d;
            w1_q  <= w1_d;
            m1_q  <= m1_d;
            v2_q  <= v2_d;
            t2_q  <= t2_d;
            a2_q  <= a2_d;
            w2_q  <= w2_d;
            m2_q  <= m2_d;
            v3_q  <= v3_d;
            ra3_q <= ra3_d;
            rb3_q <= rb3_d;
            w3_q  <= w3_d;
            m3_q  <= m3_d;
        end
    end

`ifdef BU_IFFT_HALF_EN
    logic          v4_q, v4_d;
    logic [DW-1:0] ra4_q, ra4_d, rb4_q, rb4_d, w4_q, w4_d, m4_q, m4_d;
    logic [AW-1:0] hs_a, hs_b;

    // x * 2^-1 mod q: odd x becomes even by adding the odd modulus first.
    always_comb begin
        hs_a  = AW'(ra3_q) + (ra3_q[0] ? AW'(m3_q) : '0);
        hs_b  = AW'(rb3_q) + (rb3_q[0] ? AW'(m3_q) : '0);
        v4_d  = v3_q & ~flush;
        ra4_d = DW'(hs_a >> 1);
        rb4_d = DW'(hs_b >> 1);
        w4_d  = w3_q;
        m4_d  = m3_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v4_q  <= 1'b0;
            ra4_q <= '0;
            rb4_q <= '0;
            w4_q  <= '0;
            m4_q  <= '0;
        end else begin
            v4_q  <= v4_d;
            ra4_q <= ra4_d;
            rb4_q <= rb4_d;
            w4_q  <= w4_d;
            m4_q  <= m4_d;
        end
    end

    assign out_valid   = v4_q;
    assign ifft_a      = ra4_q;
    assign ifft_b      = rb4_q;
    assign twiddle_out = w4_q;
    assign modulus_out = m4_q;
    assign busy        = v0_q | v1_q | v2_q | v3_q | v4_q;
`else
    assign out_valid   = v3_q;
    assign ifft_a      = ra3_q;
    assign ifft_b      = rb3_q;
    assign twiddle_out = w3_q;
    assign modulus_out = m3_q;
    assign busy        = v0_q | v1_q | v2_q | v3_q;
`endif

endmodule

// File: tb/tb_bu2_ifft.sv
// Bench for bu2_ifft: directed table, flush/reset sequences and random streams
// against an arithmetic model, on three instances tuned to q=17, 12289, 16383.
module tb_bu2_ifft;
    localparam int W = 15;
`ifdef BU_IFFT_HALF_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    typedef struct {
        longint ea;
        longint eb;
        longint w;
        longint q;
        int     due;
    } exp_t;

    typedef struct {
        int sel;
        int a;
        int b;
        int w;
        int q;
        int ea;
        int eb;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         flush;
    logic [W-1:0] in1, in2, tw, md;
    int           sel;

    logic         s0_v, s0_y;
    logic [5:0]   s0_a, s0_b, s0_w, s0_m;
    logic         s1_v, s1_y;
    logic [W-1:0] s1_a, s1_b, s1_w, s1_m;
    logic         s2_v, s2_y;
    logic [W-1:0] s2_a, s2_b, s2_w, s2_m;

    logic         o_v, o_y;
    logic [W-1:0] o_a, o_b, o_w, o_m;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    longint nxt_ea, nxt_eb;
    exp_t   pend[$];

    always #5 clk = ~clk;

    bu2_ifft #(.DW(6), .MU(8'd240)) u_q17 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .in1(in1[5:0]), .in2(in2[5:0]), .twiddle(tw[5:0]), .modulus(md[5:0]),
        .out_valid(s0_v), .ifft_a(s0_a), .ifft_b(s0_b),
        .twiddle_out(s0_w), .modulus_out(s0_m), .busy(s0_y)
    );

    bu2_ifft #(.DW(15), .MU(17'd87374)) u_q12289 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .in1(in1), .in2(in2), .twiddle(tw), .modulus(md),
        .out_valid(s1_v), .ifft_a(s1_a), .ifft_b(s1_b),
        .twiddle_out(s1_w), .modulus_out(s1_m), .busy(s1_y)
    );

    bu2_ifft #(.DW(15), .MU(17'd65540)) u_q16383 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .in1(in1), .in2(in2), .twiddle(tw), .modulus(md),
        .out_valid(s2_v), .ifft_a(s2_a), .ifft_b(s2_b),
        .twiddle_out(s2_w), .modulus_out(s2_m), .busy(s2_y)
    );

    always_comb begin
        o_v = 1'b0;
        o_y = 1'b0;
        o_a = '0;
        o_b = '0;
        o_w = '0;
        o_m = '0;
        case (sel)
            0: begin
                o_v = s0_v; o_y = s0_y;
                o_a = W'(s0_a); o_b = W'(s0_b);
                o_w = W'(s0_w); o_m = W'(s0_m);
            end
            1: begin
                o_v = s1_v; o_y = s1_y;
                o_a = s1_a; o_b = s1_b; o_w = s1_w; o_m = s1_m;
            end
            default: begin
                o_v = s2_v; o_y = s2_y;
                o_a = s2_a; o_b = s2_b; o_w = s2_w; o_m = s2_m;
            end
        endcase
    end

`ifdef BU_IFFT_HALF_EN
    function automatic longint half(input longint x, input longint q);
        return (x % 2 == 0) ? x / 2 : (x + q) / 2;
    endfunction
`endif

    task automatic model(input longint a, input longint b, input longint w,
                         input longint q, output longint ea, output longint eb);
        longint t;
        t  = (b * w) % q;
        ea = (a + t) % q;
        eb = (a - t + q) % q;
`ifdef BU_IFFT_HALF_EN
        ea = half(ea, q);
        eb = half(eb, q);
`endif
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input longint exp);
        checks++;
        if (act !== 64'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: update the in-flight model at the edge, then compare.
    task automatic tick();
        exp_t e;
        bit   ve;
        @(posedge clk);
        cyc++;
        if (rst || flush) begin
            pend.delete();
        end else if (in_valid) begin
            e.ea  = nxt_ea;
            e.eb  = nxt_eb;
            e.w   = longint'(tw);
            e.q   = longint'(md);
            e.due = cyc + LAT - 1;
            pend.push_back(e);
        end
        #1;
        chk("busy", 64'(o_y), longint'(pend.size() != 0));
        ve = (pend.size() != 0) && (pend[0].due == cyc);
        chk("out_valid", 64'(o_v), longint'(ve));
        if (ve) begin
            chk("ifft_a", 64'(o_a), pend[0].ea);
            chk("ifft_b", 64'(o_b), pend[0].eb);
            chk("twiddle_out", 64'(o_w), pend[0].w);
            chk("modulus_out", 64'(o_m), pend[0].q);
            void'(pend.pop_front());
        end
    endtask

    task automatic drive(input int s, input logic v, input logic fl,
                         input longint a, input longint b, input longint w,
                         input longint q, input longint ea, input longint eb);
        sel      = s;
        in_valid = v;
        flush    = fl;
        in1      = W'(a);
        in2      = W'(b);
        tw       = W'(w);
        md       = W'(q);
        nxt_ea   = ea;
        nxt_eb   = eb;
        tick();
    endtask

    task automatic drive_rand(input int s, input longint q, input logic fl);
        longint a, b, w, ea, eb;
        a = longint'($urandom_range(0, 32'(q - 1)));
        b = longint'($urandom_range(0, 32'(q - 1)));
        w = longint'($urandom_range(0, 32'(q - 1)));
        model(a, b, w, q, ea, eb);
        drive(s, 1'b1, fl, a, b, w, q, ea, eb);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        flush    = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out_valid"}, 64'(o_v), 0);
        chk({tag, "_busy"}, 64'(o_y), 0);
        chk({tag, "_ifft_a"}, 64'(o_a), 0);
        chk({tag, "_ifft_b"}, 64'(o_b), 0);
        chk({tag, "_twiddle_out"}, 64'(o_w), 0);
        chk({tag, "_modulus_out"}, 64'(o_m), 0);
    endtask

    initial begin
        vec_t tbl[3];
`ifdef BU_IFFT_HALF_EN
        tbl[0] = '{0, 3, 5, 4, 17, 3, 0};
        tbl[1] = '{0, 0, 1, 16, 17, 8, 9};
        tbl[2] = '{2, 16382, 16382, 16382, 16383, 0, 16382};
`else
        tbl[0] = '{0, 3, 5, 4, 17, 6, 0};
        tbl[1] = '{0, 0, 1, 16, 17, 16, 1};
        tbl[2] = '{2, 16382, 16382, 16382, 16383, 0, 16381};
`endif
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        in1      = '0;
        in2      = '0;
        tw       = '0;
        md       = '0;
        sel      = 0;
        nxt_ea   = 0;
        nxt_eb   = 0;

        idle(2);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk_zero("reset");
        end
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            drive(tbl[i].sel, 1'b1, 1'b0, tbl[i].a, tbl[i].b, tbl[i].w,
                  tbl[i].q, tbl[i].ea, tbl[i].eb);
            idle(LAT + 1);
        end

        for (int i = 0; i < 8; i++) drive_rand(1, 12289, 1'b0);
        idle(LAT + 2);

        for (int i = 0; i < 3; i++) drive_rand(1, 12289, 1'b0);
        drive_rand(1, 12289, 1'b1);
        idle(LAT + 2);
        drive_rand(1, 12289, 1'b0);
        idle(LAT + 1);

        drive(0, 1'b1, 1'b0, 1, 2, 3, 17, 0, 0);
        drive(0, 1'b1, 1'b0, 4, 5, 6, 17, 0, 0);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        tick();
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, tbl[0].a, tbl[0].b, tbl[0].w, tbl[0].q,
              tbl[0].ea, tbl[0].eb);
        idle(LAT + 1);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 7)
                drive_rand(1, 12289, 1'($urandom_range(0, 19) == 0));
            else
                idle(1);
        end
        idle(LAT + 1);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 8)
                drive_rand(2, 16383, 1'b0);
            else
                idle(1);
        end
        idle(LAT + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
